fft_row_unload: RTL

- Output end of the 64-point radix-4 FFT row pipeline: it drains results rather than accepting rows.
- Captures one full 64-point complex row, presented in parallel by the final FFT stage in radix-4 digit-reversed order.
- Streams the row out one complex sample per beat, in natural frequency order, under a valid/ready handshake.
- Two-bank ping-pong buffer: the next row can be captured while the current row drains.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_row_bank.sv | 33 +++
 rtl/fft_row_unload.sv | 117 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point radix-4 FFT row pipeline.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_IDX_W = 6;

  // Complex sample at the default 32-bit component width.
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } cplx32_t;

  // Radix-4 digit reversal: {d2,d1,d0} -> {d0,d1,d2}.
  function automatic logic [FFT_IDX_W-1:0] rev4(input logic [FFT_IDX_W-1:0] n);
    return {n[1:0], n[3:2], n[5:4]};
  endfunction

endpackage

// File: rtl/fft_row_bank.sv
// One 64-entry row bank: whole-row parallel write, single indexed read.
module fft_row_bank
  import fft_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [FFT_N-1:0][DW-1:0]      wr_r,
  input  logic [FFT_N-1:0][DW-1:0]      wr_i,
  input  logic [FFT_IDX_W-1:0]          rd_addr,
  output logic [DW-1:0]                 rd_r,
  output logic [DW-1:0]                 rd_i
);

  logic [FFT_N-1:0][DW-1:0] mem_r_q;
  logic [FFT_N-1:0][DW-1:0] mem_i_q;

  // Row storage; data-only registers, deliberately left without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r_q <= wr_r;
      mem_i_q <= wr_i;
    end else begin
      mem_r_q <= mem_r_q;
      mem_i_q <= mem_i_q;
    end
  end

  assign rd_r = mem_r_q[rd_addr];
  assign rd_i = mem_i_q[rd_addr];

endmodule

// File: rtl/fft_row_unload.sv
// Output end of the FFT row pipeline: captures a digit-reversed parallel row
// into a ping-pong bank pair and streams it out in natural order.
module fft_row_unload
  import fft_pkg::*;
#(
  parameter int DW             = 32,
  parameter int BYPASS_REORDER = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FFT_N-1:0][DW-1:0] in_r,
  input  logic [FFT_N-1:0][DW-1:0] in_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_r,
  output logic [DW-1:0]            out_i,
  output logic [FFT_IDX_W-1:0]     out_idx,
  output logic                     out_last,
  output logic [1:0]               rows_pending
);

  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [FFT_IDX_W-1:0] rd_cnt_q, rd_cnt_d;

  logic                 capture;
  logic                 beat;
  logic [FFT_IDX_W-1:0] rd_addr;
  logic [DW-1:0]        b0_r, b0_i, b1_r, b1_i;

  assign in_ready     = !full_q[wr_bank_q];
  assign out_valid    = full_q[rd_bank_q];
  assign rows_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign capture      = in_valid && in_ready;
  assign beat         = out_valid && out_ready;
  assign out_idx      = rd_cnt_q;
  assign out_last     = out_valid && (rd_cnt_q == 6'd63);
  assign rd_addr      = (BYPASS_REORDER != 0) ? rd_cnt_q : rev4(rd_cnt_q);

  fft_row_bank #(.DW(DW)) u_bank0 (
    .clk     (clk),
    .we      (capture && !wr_bank_q),
    .wr_r    (in_r),
    .wr_i    (in_i),
    .rd_addr (rd_addr),
    .rd_r    (b0_r),
    .rd_i    (b0_i)
  );

  fft_row_bank #(.DW(DW)) u_bank1 (
    .clk     (clk),
    .we      (capture && wr_bank_q),
    .wr_r    (in_r),
    .wr_i    (in_i),
    .rd_addr (rd_addr),
    .rd_r    (b1_r),
    .rd_i    (b1_i)
  );

  // Output mux: select the draining bank, zero the data when nothing is valid.
  always_comb begin
    out_r = '0;
    out_i = '0;
    if (out_valid) begin
      out_r = rd_bank_q ? b1_r : b0_r;
      out_i = rd_bank_q ? b1_i : b0_i;
    end else begin
      out_r = '0;
      out_i = '0;
    end
  end

  // Next state: capture fills the write bank, the last beat frees the read bank.
  // Both may happen on one edge; they always target different banks.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    if (capture) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (beat) begin
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = 6'd0;
      end else begin
        rd_cnt_d = rd_cnt_q + 6'd1;
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 6'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

endmodule
